// File: rtl/datapath_core_if.sv
// Control/data bundle between the control unit and the single-bus datapath.
// The control unit drives selects, opcode and external data; the datapath returns the bus value.
interface datapath_core_if;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [31:0] inPort;
  logic [31:0] MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;

  modport master (
    output enable, busSelect, inPort, MDataIn, MD_Read, Control_Signals,
    input  busMuxOut
  );

  modport slave (
    input  enable, busSelect, inPort, MDataIn, MD_Read, Control_Signals,
    output busMuxOut
  );
endinterface

// File: rtl/datapath_core.sv
// 32-bit single-bus datapath: GPRs, special registers, MDR and a 64-bit-result ALU
// all sourced from and loaded off one combinational internal bus.
module datapath_core (
  input  logic            clk,
  input  logic            clr,
  datapath_core_if.slave  dp
);
  logic [31:0] gpr_reg [16];
  logic [31:0] hi_reg, lo_reg, y_reg, pc_reg, mdr_reg, ir_reg, mar_reg;
  logic [63:0] z_reg;
  logic [31:0] bus;
  logic [4:0]  dest;

  // Any nonzero upper enable bit suppresses every load.
  assign dest = (dp.enable[31:5] == 27'd0) ? dp.enable[4:0] : 5'd0;

  always_comb begin
    case (dp.busSelect)
      32'd16:  bus = hi_reg;
      32'd17:  bus = lo_reg;
      32'd18:  bus = z_reg[63:32];
      32'd19:  bus = z_reg[31:0];
      32'd20:  bus = pc_reg;
      32'd21:  bus = mdr_reg;
      32'd22:  bus = dp.inPort;
      32'd23:  bus = ir_reg;
      32'd24:  bus = y_reg;
      32'd25:  bus = mar_reg;
      default: bus = (dp.busSelect < 32'd16) ? gpr_reg[dp.busSelect[3:0]] : 32'd0;
    endcase
  end

  assign dp.busMuxOut = bus;

  // R0 sits on destination code 16 so that code 0 can mean "no load".
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_gpr
      localparam logic [4:0] CODE = (gi == 0) ? 5'd16 : 5'(gi);
      always_ff @(posedge clk) begin
        if (!clr)
          gpr_reg[gi] <= 32'd0;
        else if (dest == CODE)
          gpr_reg[gi] <= bus;
      end
    end
  endgenerate

  logic [31:0] a, b;
  logic [4:0]  amt;
  logic signed [63:0] a_ext, b_ext, prod;
  logic [63:0] rot_r, rot_l;
  logic [31:0] quo, rem, r32;
  logic [63:0] alu_out;

  assign a     = y_reg;
  assign b     = bus;
  assign amt   = b[4:0];
  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign prod  = a_ext * b_ext;
  assign rot_r = {a, a} >> amt;
  assign rot_l = {a, a} << amt;

  always_comb begin
    if (b == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = a;
    end else begin
      quo = 32'($signed(a) / $signed(b));
      rem = 32'($signed(a) % $signed(b));
    end
  end

  always_comb begin
    r32 = 32'd0;
    case (dp.Control_Signals)
      4'd0:    r32 = a + b;
      4'd1:    r32 = a - b;
      4'd4:    r32 = a >> amt;
      4'd5:    r32 = a & b;
      4'd6:    r32 = a | b;
      4'd7:    r32 = a << amt;
      4'd8:    r32 = rot_r[31:0];
      4'd9:    r32 = rot_l[63:32];
      4'd10:   r32 = 32'd0 - b;
      4'd11:   r32 = ~b;
      4'd12:   r32 = b + 32'd1;
      4'd13:   r32 = 32'($signed(a) >>> amt);
      default: r32 = b;
    endcase
  end

  always_comb begin
    alu_out = {{32{r32[31]}}, r32};
    if (dp.Control_Signals == 4'd2)
      alu_out = prod;
    else if (dp.Control_Signals == 4'd3)
      alu_out = {rem, quo};
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      hi_reg  <= 32'd0;
      lo_reg  <= 32'd0;
      y_reg   <= 32'd0;
      pc_reg  <= 32'd0;
      mdr_reg <= 32'd0;
      ir_reg  <= 32'd0;
      mar_reg <= 32'd0;
      z_reg   <= 64'd0;
    end else begin
      case (dest)
        5'd17: hi_reg  <= bus;
        5'd18: lo_reg  <= bus;
        5'd19: y_reg   <= bus;
        5'd20: pc_reg  <= bus;
        5'd21: mdr_reg <= dp.MD_Read ? dp.MDataIn : bus;
        5'd23: ir_reg  <= bus;
        5'd24: z_reg   <= alu_out;
        5'd25: mar_reg <= bus;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: expected bus values are queued when a read is
// issued and popped/compared at the following falling edge.
module tb_datapath_core;
  logic clk = 1'b0;
  logic clr;
  datapath_core_if dif ();

  datapath_core dut (.clk(clk), .clr(clr), .dp(dif.slave));

  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic step(input logic [31:0] en, input logic [31:0] sel,
                      input logic [3:0] op = 4'd0);
    dif.enable          = en;
    dif.busSelect       = sel;
    dif.Control_Signals = op;
    @(posedge clk);
    #1;
    dif.MD_Read = 1'b0;
  endtask

  task automatic load(input logic [31:0] en, input logic [31:0] val);
    dif.inPort = val;
    step(en, 32'd22);
  endtask

  task automatic check(input logic [31:0] sel, input logic [31:0] exp, input string tag);
    logic [31:0] obs, want;
    string t;
    dif.enable    = 32'd0;
    dif.busSelect = sel;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    obs  = dif.busMuxOut;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_checks++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", t, obs, want);
    end
    $display("check %-12s sel=%0d observed=%h expected=%h", t, sel, obs, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0;
    dif.enable = 32'd0; dif.busSelect = 32'd0; dif.inPort = 32'hA5A5_0001;
    dif.MDataIn = 32'd0; dif.MD_Read = 1'b0; dif.Control_Signals = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    check(32'd22, 32'hA5A5_0001, "rst_inport");
    check(32'd19, 32'd0, "rst_zlow");

    // Make every register nonzero, then reset for one edge.
    for (int i = 1; i <= 21; i++) load(32'(i), 32'h8000_0100 + 32'(i));
    load(32'd23, 32'h8000_0123);
    load(32'd25, 32'h8000_0125);
    dif.inPort = 32'h8000_0001;
    step(32'd24, 32'd22, 4'd15);
    check(32'd18, 32'hFFFF_FFFF, "pre_zhigh");
    clr = 1'b0;
    step(32'd0, 32'd0);
    clr = 1'b1;
    for (int s = 0; s <= 25; s++)
      if (s != 22) check(32'(s), 32'd0, $sformatf("rst_sel%0d", s));

    // MDR from memory, then into R2.
    dif.MDataIn = 32'h12; dif.MD_Read = 1'b1;
    step(32'd21, 32'd0);
    step(32'd2, 32'd21);
    check(32'd2, 32'h12, "mdr_r2");

    // OR and NOT with Y = R2.
    load(32'd3, 32'h14);
    step(32'd19, 32'd2);
    step(32'd24, 32'd3, 4'd6);
    check(32'd19, 32'h16, "or_zlow");
    check(32'd18, 32'h0, "or_zhigh");
    step(32'd24, 32'd3, 4'd11);
    check(32'd19, 32'hFFFF_FFEB, "not_zlow");
    check(32'd18, 32'hFFFF_FFFF, "not_zhigh");

    // MUL / DIV.
    load(32'd19, 32'hFFFF_FFFE);
    load(32'd4, 32'd3);
    step(32'd24, 32'd4, 4'd2);
    check(32'd19, 32'hFFFF_FFFA, "mul_zlow");
    check(32'd18, 32'hFFFF_FFFF, "mul_zhigh");
    load(32'd19, 32'd7);
    load(32'd5, 32'd2);
    step(32'd24, 32'd5, 4'd3);
    check(32'd19, 32'd3, "div_quo");
    check(32'd18, 32'd1, "div_rem");
    load(32'd6, 32'd0);
    step(32'd24, 32'd6, 4'd3);
    check(32'd19, 32'hFFFF_FFFF, "div0_quo");
    check(32'd18, 32'd7, "div0_rem");

    // Wrap, shifts and rotates.
    load(32'd19, 32'h7FFF_FFFF);
    load(32'd7, 32'd1);
    step(32'd24, 32'd7, 4'd0);
    check(32'd19, 32'h8000_0000, "add_wrap_lo");
    check(32'd18, 32'hFFFF_FFFF, "add_wrap_hi");
    load(32'd19, 32'd3);
    load(32'd8, 32'd5);
    step(32'd24, 32'd8, 4'd1);
    check(32'd19, 32'hFFFF_FFFE, "sub_lo");
    step(32'd24, 32'd8, 4'd10);
    check(32'd19, 32'hFFFF_FFFB, "neg_lo");
    load(32'd19, 32'h8000_0001);
    load(32'd9, 32'h0000_0024);
    step(32'd24, 32'd9, 4'd8);
    check(32'd19, 32'h1800_0000, "ror_lo");
    check(32'd18, 32'h0, "ror_hi");
    step(32'd24, 32'd9, 4'd9);
    check(32'd19, 32'h0000_0018, "rol_lo");
    step(32'd24, 32'd9, 4'd13);
    check(32'd19, 32'hF800_0000, "shra_lo");
    step(32'd24, 32'd9, 4'd4);
    check(32'd19, 32'h0800_0000, "shr_lo");
    step(32'd24, 32'd9, 4'd7);
    check(32'd19, 32'h0000_0010, "shl_lo");

    // PC increment through Z, then self-reload.
    load(32'd20, 32'd5);
    step(32'd24, 32'd20, 4'd12);
    step(32'd20, 32'd19);
    check(32'd20, 32'd6, "pc_inc");
    step(32'd20, 32'd20);
    check(32'd20, 32'd6, "pc_self");

    // Enable with upper bits set must not load; out-of-range select reads 0.
    load(32'd1, 32'h11);
    load(32'h0000_0021, 32'h99);
    check(32'd1, 32'h11, "en_upper");
    load(32'd16, 32'h77);
    check(32'd0, 32'h77, "r0_load");
    check(32'h100, 32'd0, "sel_range");

    // Reset beats a pending load.
    clr = 1'b0;
    load(32'd2, 32'h55);
    clr = 1'b1;
    check(32'd2, 32'd0, "rst_pending");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
